cdc_multi_sync: RTL

CDC_MULTI_SYNC -- requirements
Module: cdc_multi_sync

---
 rtl/cdc_multi_sync.sv | 104 ++++++++++
 1 files changed

// File: rtl/cdc_multi_sync.sv
// cdc_multi_sync: per-channel multi-flop synchronizer with optional debounce
// filter, registered edge/toggle pulses and a clearable sticky event flag.
// Every channel is fully independent; nothing combines channels before sync_q.
`timescale 1ns/1ps

module cdc_multi_sync #(
  parameter int               WIDTH    = 4,
  parameter int               STAGES   = 2,
  parameter int               FILT_CNT = 0,
  parameter int               MODE     = 0,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] evt_sticky
);

  logic [WIDTH-1:0] sync_ff [STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] level_p1;

  // Synchronizer chain: stage 0 samples the raw asynchronous input directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) sync_ff[s] <= RST_VAL;
    end else begin
      sync_ff[0] <= async_in;
      for (int s = 1; s < STAGES; s++) sync_ff[s] <= sync_ff[s-1];
    end
  end

  assign sync_q = sync_ff[STAGES-1];

  if (FILT_CNT == 0) begin : g_bypass
    // No debounce: level follows the synchronized value one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) level_out <= RST_VAL;
      else        level_out <= sync_q;
    end
  end else begin : g_filt
    localparam int            CW       = $clog2(FILT_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    logic [CW-1:0] cnt [WIDTH];

    // Debounce: level only moves after FILT_CNT consecutive differing samples;
    // the counter tops out at CNT_LAST and clears, so it can never wrap
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_out <= RST_VAL;
        for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_q[i] == level_out[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == CNT_LAST) begin
            level_out[i] <= sync_q[i];
            cnt[i]       <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Previous level, reset to RST_VAL so release never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_p1 <= RST_VAL;
    else        level_p1 <= level_out;
  end

  if (MODE == 0) begin : g_level
    // Level mode: separate registered rise and fall pulses
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_pulse <= '0;
        fall_pulse <= '0;
      end else begin
        rise_pulse <= level_out & ~level_p1;
        fall_pulse <= ~level_out & level_p1;
      end
    end
  end else begin : g_toggle
    // Toggle mode: one registered pulse per change in either direction
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rise_pulse <= '0;
      else        rise_pulse <= level_out ^ level_p1;
    end
    assign fall_pulse = '0;
  end

  // Sticky flag: any pulse sets it, evt_clr clears it, set wins a tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_sticky <= '0;
    else        evt_sticky <= (evt_sticky & ~evt_clr) | rise_pulse | fall_pulse;
  end

endmodule
